interrupt_controller: RTL

- Parametrised multi-source interrupt controller for the 16-bit processor. It generalises the single interruptSignal input to NUM_IRQ independent lines.
- Features: rising-edge capture, per-line mask, fixed priority, request/acknowledge handshake with the processor controller, vector output, and return-from-interrupt (RTI) release.
- Sits between external interrupt pins and the Controller's fetch/PC-select logic.

---
 rtl/interrupt_controller_pkg.sv | 24 ++
 rtl/interrupt_controller_priority_encoder.sv | 28 ++
 rtl/interrupt_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the multi-source interrupt controller.
// Contents:
//   ic_state_e          - controller FSM states (idle, request, in service)
//   DefaultVecBase      - default vector address of line 0
//   DefaultVecStride    - default spacing between line vectors
//   IntVectorTableBase  - vector-table base constant used by the processor controller
//   id_width()          - width of a line index for a given line count (min 1)
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IcIdle    = 2'd0,
        IcReq     = 2'd1,
        IcService = 2'd2
    } ic_state_e;

    localparam logic [15:0] DefaultVecBase     = 16'h0002;
    localparam int unsigned DefaultVecStride   = 2;
    localparam logic [15:0] IntVectorTableBase = 16'h0002;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Combinational fixed-priority encoder: reports the lowest set bit of req_i.
// Ports:
//   req_i   - request vector
//   valid_o - at least one request bit is set
//   idx_o   - index of the lowest set bit (0 when nothing is set)
module interrupt_controller_priority_encoder
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4,
    localparam int unsigned IdW = id_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [IdW-1:0]     idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IdW'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller: rising-edge capture, per-line mask, fixed priority
// (line 0 highest), request/ack handshake, vector output and RTI release. No nesting.
// Optional feature: define IRQ_SYNC_EN to pass irq_in_i through a 2-flop synchroniser
// before edge detection (edge-to-request latency 4 cycles instead of 2).
// Ports:
//   clk_i, rst_ni  - clock (rising edge), asynchronous active-low reset
//   irq_in_i       - raw interrupt lines, rising edge requests service
//   mask_we_i      - mask register write enable; mask_wdata_i new mask (1 = enabled)
//   int_ack_i      - controller accepts the current request (pulse)
//   int_done_i     - controller executed RTI (pulse)
//   int_req_o      - interrupt request; int_vec_o / int_id_o describe the granted line
//   pending_o      - latched pending bits (unmasked view)
//   in_service_o   - high from ack until done
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned           NUM_IRQ    = 4,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = ADDR_WIDTH'(DefaultVecBase),
    parameter int unsigned           VEC_STRIDE = DefaultVecStride,
    localparam int unsigned          IdW        = id_width(NUM_IRQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_IRQ-1:0]    irq_in_i,
    input  logic                  mask_we_i,
    input  logic [NUM_IRQ-1:0]    mask_wdata_i,
    input  logic                  int_ack_i,
    input  logic                  int_done_i,
    output logic                  int_req_o,
    output logic [ADDR_WIDTH-1:0] int_vec_o,
    output logic [IdW-1:0]        int_id_o,
    output logic [NUM_IRQ-1:0]    pending_o,
    output logic                  in_service_o
);

    logic [NUM_IRQ-1:0]    irq_s;
    logic [NUM_IRQ-1:0]    irq_prev_q;
    logic [NUM_IRQ-1:0]    rise;
    logic [NUM_IRQ-1:0]    pending_q, pending_d;
    logic [NUM_IRQ-1:0]    mask_q, mask_d;
    ic_state_e             state_q, state_d;
    logic                  int_req_q, int_req_d;
    logic                  in_service_q, in_service_d;
    logic [IdW-1:0]        int_id_q, int_id_d;
    logic [ADDR_WIDTH-1:0] int_vec_q, int_vec_d;
    logic                  cand_valid;
    logic [IdW-1:0]        cand_idx;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in_i;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in_i;
`endif

    assign rise = irq_s & ~irq_prev_q;

    interrupt_controller_priority_encoder #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req_i   (pending_q & mask_q),
        .valid_o (cand_valid),
        .idx_o   (cand_idx)
    );

    always_comb begin
        pending_d = pending_q;
        if (state_q == IcReq && int_ack_i) begin
            pending_d = pending_d & ~(NUM_IRQ'(1) << int_id_q);
        end
        // A new edge on the acknowledged line wins over the clear.
        pending_d = pending_d | rise;
        mask_d    = mask_we_i ? mask_wdata_i : mask_q;
    end

    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        in_service_d = in_service_q;
        int_id_d     = int_id_q;
        int_vec_d    = int_vec_q;
        unique case (state_q)
            IcIdle: begin
                if (cand_valid) begin
                    state_d   = IcReq;
                    int_req_d = 1'b1;
                    int_id_d  = cand_idx;
                    int_vec_d = VEC_BASE + ADDR_WIDTH'(cand_idx) * ADDR_WIDTH'(VEC_STRIDE);
                end
            end
            IcReq: begin
                // Ack has priority over a simultaneous done and over withdrawal.
                if (int_ack_i) begin
                    state_d      = IcService;
                    int_req_d    = 1'b0;
                    in_service_d = 1'b1;
                end else if (!mask_q[int_id_q]) begin
                    state_d   = IcIdle;
                    int_req_d = 1'b0;
                end
            end
            IcService: begin
                if (int_done_i) begin
                    state_d      = IcIdle;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = IcIdle;
                int_req_d    = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= '1;
            state_q      <= IcIdle;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b0;
            int_id_q     <= '0;
            int_vec_q    <= '0;
        end else begin
            irq_prev_q   <= irq_s;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            in_service_q <= in_service_d;
            int_id_q     <= int_id_d;
            int_vec_q    <= int_vec_d;
        end
    end

    assign int_req_o    = int_req_q;
    assign int_vec_o    = int_vec_q;
    assign int_id_o     = int_id_q;
    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule
